// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Parametrised UART receiver with 2-flop input synchroniser,
//            start-bit glitch rejection, framing-error detection and a
//            receive FIFO with valid/ready read side and sticky overrun flag.
//            Optional parity checking is compiled in with the macro
//            UART_RX_PARITY_EN (default build: no parity bit, rperr_o = 0).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 921600,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rxd_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 rferr_o,
  output logic                 rperr_o,
  output logic                 overrun_o,
  input  logic                 ovr_clr_i
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int WAIT_COUNT = (CLK_FREQ_MHZ * 1000000) / BAUD_RATE;
  localparam int HALF_COUNT = (WAIT_COUNT + 1) / 2;
  localparam int TW         = $clog2(WAIT_COUNT);
  localparam int BW         = $clog2(DATA_BITS + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int PW         = AW + 1;

`ifdef UART_RX_PARITY_EN
  localparam int PAR_W = 1;
  localparam logic c_PAR_ODD = PARITY_ODD[0];
`else
  localparam int PAR_W = 0;
`endif
  // FIFO entry: {[perr], ferr, data}
  localparam int EW = DATA_BITS + 1 + PAR_W;

  localparam logic [TW-1:0] c_HALF_M1 = TW'(HALF_COUNT - 1);
  localparam logic [TW-1:0] c_WAIT_M1 = TW'(WAIT_COUNT - 1);
  localparam logic [BW-1:0] c_DATA_M1 = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] c_STOP_M1 = BW'(STOP_BITS - 1);

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic                 sync1_q;
  logic                 rxd_q;

  logic [2:0]           state_q,  state_d;
  logic [TW-1:0]        timer_q,  timer_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q,   perr_d;
`endif
  logic                 w_tick;
  logic                 w_push;
  logic [EW-1:0]        w_entry;

  logic [EW-1:0]        mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 overrun_q, overrun_d;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [EW-1:0]        w_head;

  // Bit timer expiry marks a sampling point (start midpoint or bit midpoint).
  assign w_tick = (timer_q == '0);

  // --------------------------------------------------------------------------
  // Input synchroniser: two flops, idle-high reset so no false start edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      rxd_q   <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxd_q   <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register together with the receive datapath registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  // Next-state logic: frame sequencing driven by the sampling ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rxd_q) state_d = S_START;
      S_START:  if (w_tick) state_d = rxd_q ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_tick && (bitcnt_q == '0)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_tick) state_d = S_STOP;
`endif
      S_STOP:   if (w_tick && (bitcnt_q == '0)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: timer reloads, bit counting, shifting, error
  // accumulation and the push strobe on the last stop-bit sample.
  always_comb begin
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    ferr_d   = ferr_q;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
`endif
    w_push   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Preload so the first sample lands at the start-bit midpoint.
        timer_d = c_HALF_M1;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
`endif
      end
      S_START: begin
        if (w_tick) begin
          timer_d  = c_WAIT_M1;
          bitcnt_d = c_DATA_M1;
        end else begin
          timer_d  = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          // LSB first: shift right, newest bit enters at the top.
          shift_d = {rxd_q, shift_q[DATA_BITS-1:1]};
          timer_d = c_WAIT_M1;
          if (bitcnt_q == '0) bitcnt_d = c_STOP_M1;
          else                bitcnt_d = bitcnt_q - BW'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          perr_d   = ((^shift_q) ^ rxd_q) != c_PAR_ODD;
          timer_d  = c_WAIT_M1;
          bitcnt_d = c_STOP_M1;
        end else begin
          timer_d  = timer_q - TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          ferr_d  = ferr_q | ~rxd_q;
          timer_d = c_WAIT_M1;
          if (bitcnt_q == '0) w_push   = 1'b1;
          else                bitcnt_d = bitcnt_q - BW'(1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Word handed to the FIFO; ferr_d already includes the final stop sample.
`ifdef UART_RX_PARITY_EN
  assign w_entry = {perr_q, ferr_d, shift_q};
`else
  assign w_entry = {ferr_d, shift_q};
`endif

  // --------------------------------------------------------------------------
  // Receive FIFO: wrap-bit pointers, push accepted when full only if the
  // head is popped in the same cycle.
  // --------------------------------------------------------------------------
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop     = !w_empty && rready_i;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // Pointer and overrun next-state; a new overrun beats a simultaneous clear.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (w_push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (w_pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (w_drop)         overrun_d = 1'b1;
    else if (ovr_clr_i) overrun_d = 1'b0;
  end

  // FIFO pointers and sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) mem_q[wr_ptr_q[AW-1:0]] <= w_entry;
  end

  assign w_head    = mem_q[rd_ptr_q[AW-1:0]];
  assign rvalid_o  = !w_empty;
  assign rdata_o   = w_head[DATA_BITS-1:0];
  assign rferr_o   = w_head[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign rperr_o   = w_head[DATA_BITS+1];
`else
  assign rperr_o   = 1'b0;
`endif
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (8N1 and 7N2
//            instances at WAIT_COUNT=10). Parity cases run when
//            UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // Push is seen 98 cycles after the start edge is driven (2 sync stages,
  // 1 IDLE cycle, half bit, 9 full bits), plus one bit time with parity.
  localparam int LAT = 98 + 10 * PB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd, rxd2;
  logic       rready, rready2;
  logic       ovr_clr, ovr_clr2;
  logic       rvalid, rvalid2;
  logic [7:0] rdata;
  logic [6:0] rdata2;
  logic       rferr, rferr2, rperr, rperr2, overrun, overrun2;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int t0;

  logic [9:0] cap1 [$];
  int         cyc1 [$];
  logic [9:0] cap2 [$];
  int         cyc2 [$];
  logic [9:0] e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fifo #(.CLK_FREQ_MHZ(10), .BAUD_RATE(1000000), .DATA_BITS(8),
                 .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd), .rvalid_o(rvalid),
    .rready_i(rready), .rdata_o(rdata), .rferr_o(rferr), .rperr_o(rperr),
    .overrun_o(overrun), .ovr_clr_i(ovr_clr));

  uart_rx_fifo #(.CLK_FREQ_MHZ(10), .BAUD_RATE(1000000), .DATA_BITS(7),
                 .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut7 (
    .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd2), .rvalid_o(rvalid2),
    .rready_i(rready2), .rdata_o(rdata2), .rferr_o(rferr2), .rperr_o(rperr2),
    .overrun_o(overrun2), .ovr_clr_i(ovr_clr2));

  // Record every accepted head word as {perr, ferr, data} with its cycle.
  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      cap1.push_back({rperr, rferr, rdata});
      cyc1.push_back(cyc);
    end
    if (rst_n && rvalid2 && rready2) begin
      cap2.push_back({rperr2, rferr2, 1'b0, rdata2});
      cyc2.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rxd = v;
    else            rxd2 = v;
  endtask

  task automatic hold_bit(input int which, input logic v);
    tick();
    set_line(which, v);
    repeat (9) tick();
  endtask

  // Drive one frame: start, data LSB first, [parity], stop bits, idle high.
  task automatic send(input int which, input logic [8:0] d, input int nbits,
                      input int nstop, input logic s1, input logic s2,
                      input logic pflip, input int idle, output int ts);
    logic p;
    p = 1'b0;
    tick();
    set_line(which, 1'b0);
    ts = cyc;
    repeat (9) tick();
    for (int i = 0; i < nbits; i++) begin
      hold_bit(which, d[i]);
      p = p ^ d[i];
    end
    if (PB == 1) hold_bit(which, p ^ pflip);
    hold_bit(which, s1);
    if (nstop == 2) hold_bit(which, s2);
    tick();
    set_line(which, 1'b1);
    repeat (idle) tick();
  endtask

  function automatic logic [9:0] get1(input int i);
    if (i < cap1.size()) return cap1[i];
    return 'x;
  endfunction

  function automatic logic [9:0] get2(input int i);
    if (i < cap2.size()) return cap2[i];
    return 'x;
  endfunction

  function automatic int gcyc1(input int i);
    if (i < cyc1.size()) return cyc1[i];
    return -1;
  endfunction

  function automatic int gcyc2(input int i);
    if (i < cyc2.size()) return cyc2[i];
    return -1;
  endfunction

  initial begin
    rst_n = 1'b0; rxd = 1'b1; rxd2 = 1'b1;
    rready = 1'b1; rready2 = 1'b1; ovr_clr = 1'b0; ovr_clr2 = 1'b0;
    repeat (3) tick();
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rvalid7", 32'(rvalid2), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // 0xA5 8N1, consumer always ready
    send(0, 9'h0A5, 8, 1, 1'b1, 1'b1, 1'b0, 10, t0);
    chk("a5_count", 32'(cap1.size()), 32'd1);
    e = get1(0);
    chk("a5_data", 32'(e[7:0]), 32'h0A5);
    chk("a5_ferr", 32'(e[8]), 32'd0);
    chk("a5_perr", 32'(e[9]), 32'd0);
    chk("a5_latency", 32'(gcyc1(0) - t0), 32'(LAT));
    chk("a5_empty", 32'(rvalid), 32'd0);
    cap1.delete(); cyc1.delete();

    // Start glitch of 3 cycles is rejected
    tick(); rxd = 1'b0;
    repeat (3) tick();
    rxd = 1'b1;
    repeat (20) tick();
    chk("glitch_nopush", 32'(cap1.size()), 32'd0);
    chk("glitch_rvalid", 32'(rvalid), 32'd0);
    send(0, 9'h03C, 8, 1, 1'b1, 1'b1, 1'b0, 10, t0);
    chk("3c_count", 32'(cap1.size()), 32'd1);
    e = get1(0);
    chk("3c_data", 32'(e[7:0]), 32'h03C);
    cap1.delete(); cyc1.delete();

    // Framing error word is kept; next frame clean
    send(0, 9'h055, 8, 1, 1'b0, 1'b1, 1'b0, 20, t0);
    send(0, 9'h00F, 8, 1, 1'b1, 1'b1, 1'b0, 10, t0);
    chk("ferr_count", 32'(cap1.size()), 32'd2);
    e = get1(0);
    chk("55_data", 32'(e[7:0]), 32'h055);
    chk("55_ferr", 32'(e[8]), 32'd1);
    e = get1(1);
    chk("0f_data", 32'(e[7:0]), 32'h00F);
    chk("0f_ferr", 32'(e[8]), 32'd0);
    cap1.delete(); cyc1.delete();

    // Stalled consumer: five back-to-back frames into a 4-deep FIFO
    rready = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 9'(i), 8, 1, 1'b1, 1'b1, 1'b0, 0, t0);
    chk("full_no_ovr", 32'(overrun), 32'd0);
    chk("full_rvalid", 32'(rvalid), 32'd1);
    chk("full_head", 32'(rdata), 32'h01);
    send(0, 9'h005, 8, 1, 1'b1, 1'b1, 1'b0, 2, t0);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_head_stable", 32'(rdata), 32'h01);
    tick(); rready = 1'b1;
    repeat (6) tick();
    rready = 1'b0;
    chk("drain_count", 32'(cap1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = get1(i);
      chk($sformatf("drain_%0d", i), 32'(e[7:0]), 32'(i + 1));
    end
    chk("drain_empty", 32'(rvalid), 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);
    cap1.delete(); cyc1.delete();
    rready = 1'b1;

    // 7 data bits, 2 stop bits, second stop bit low
    send(1, 9'h07F, 7, 2, 1'b1, 1'b0, 1'b0, 20, t0);
    chk("7f_count", 32'(cap2.size()), 32'd1);
    e = get2(0);
    chk("7f_data", 32'(e[6:0]), 32'h7F);
    chk("7f_ferr", 32'(e[8]), 32'd1);
    chk("7f_latency", 32'(gcyc2(0) - t0), 32'(LAT));
    send(1, 9'h02A, 7, 2, 1'b1, 1'b1, 1'b0, 10, t0);
    e = get2(1);
    chk("2a_data", 32'(e[6:0]), 32'h2A);
    chk("2a_ferr", 32'(e[8]), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 needs parity bit 0
    send(0, 9'h003, 8, 1, 1'b1, 1'b1, 1'b0, 10, t0);
    send(0, 9'h003, 8, 1, 1'b1, 1'b1, 1'b1, 10, t0);
    chk("par_count", 32'(cap1.size()), 32'd2);
    e = get1(0);
    chk("par_ok_data", 32'(e[7:0]), 32'h03);
    chk("par_ok_perr", 32'(e[9]), 32'd0);
    e = get1(1);
    chk("par_bad_data", 32'(e[7:0]), 32'h03);
    chk("par_bad_perr", 32'(e[9]), 32'd1);
`else
    send(0, 9'h0C3, 8, 1, 1'b1, 1'b1, 1'b0, 10, t0);
    e = get1(0);
    chk("c3_data", 32'(e[7:0]), 32'h0C3);
    chk("c3_perr_tied", 32'(e[9]), 32'd0);
`endif
    cap1.delete(); cyc1.delete();

    // Reset mid-frame flushes a stored word and abandons the frame
    rready = 1'b0;
    send(0, 9'h099, 8, 1, 1'b1, 1'b1, 1'b0, 5, t0);
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    chk("pre_rst_head", 32'(rdata), 32'h99);
    tick(); rxd = 1'b0;
    repeat (30) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    rxd = 1'b1;
    repeat (30) tick();
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    chk("post_rst_ovr", 32'(overrun), 32'd0);
    rready = 1'b1;
    send(0, 9'h05A, 8, 1, 1'b1, 1'b1, 1'b0, 10, t0);
    chk("post_rst_count", 32'(cap1.size()), 32'd1);
    e = get1(0);
    chk("post_rst_data", 32'(e[7:0]), 32'h05A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, next generation of the single-byte receiver. Configurable data width and stop-bit count, start-bit glitch rejection, framing-error detection, and a receive FIFO so back-to-back frames are not lost when the consumer stalls. Sits between the rxd pin and any valid/ready byte consumer (command decoder, bus bridge).

Parameters:
CLK_FREQ_MHZ, 100, system clock frequency in MHz
BAUD_RATE, 921600, line rate in bit/s; WAIT_COUNT = (CLK_FREQ_MHZ*1000000)/BAUD_RATE, must be >= 4
DATA_BITS, 8, data bits per frame, legal 5..9, LSB first
STOP_BITS, 1, stop bits checked, legal 1 or 2
FIFO_DEPTH, 4, receive FIFO entries, power of two >= 2
PARITY_ODD, 0, parity sense when parity compiled in (0 even, 1 odd); ignored otherwise

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_ni  in  1  synchronous active-low reset
rxd_i  in  1  asynchronous serial input, idle high
rvalid_o  out  1  FIFO head valid
rready_i  in  1  consumer accepts head; pop when rvalid_o && rready_i
rdata_o  out  DATA_BITS  FIFO head data
rferr_o  out  1  head word had framing error (a stop bit sampled 0)
rperr_o  out  1  head word had parity error; constant 0 when parity not compiled in
overrun_o  out  1  sticky: a completed frame was dropped because FIFO full
ovr_clr_i  in  1  clears overrun_o

Behaviour:
- Reset: rvalid_o=0, overrun_o=0, FIFO empty, FSM IDLE, synchroniser stages =1. rdata_o/rferr_o/rperr_o undefined while rvalid_o=0.
- rxd_i through 2-flop synchroniser (reset 1); all decisions use the second stage (rxd).
- FSM states: IDLE, START, DATA, PARITY (only if compiled in), STOP.
- IDLE: rxd==0 -> START, bit timer loaded so next sample is at start-bit midpoint ((WAIT_COUNT+1)/2 cycles later).
- START at midpoint: rxd==1 -> glitch, back to IDLE, nothing pushed; rxd==0 -> DATA, timer reloaded WAIT_COUNT-1, bit counter = DATA_BITS-1.
- DATA: sample every WAIT_COUNT cycles at bit midpoint, shift in LSB first; after bit counter reaches 0 -> PARITY or STOP.
- STOP: sample STOP_BITS stop bits at midpoints; any 0 sets frame ferr. On last stop sample: push {data, ferr, perr} and go to IDLE in the same cycle (next start edge detectable the following cycle, no full-bit wait).
- Framing-error frames are pushed, not discarded.
- FIFO: push when not full, or when full and pop in the same cycle. Push into full FIFO without pop: word dropped, overrun_o set next cycle, FIFO content unchanged.
- overrun_o: stays 1 until ovr_clr_i; set and clear same cycle -> set wins.
- Latency: push into empty FIFO -> rvalid_o=1 on next cycle, head data valid same cycle. Simultaneous push+pop on 1-entry FIFO: rvalid_o stays 1, new word presented next cycle.
- rvalid_o/rdata_o stable while rvalid_o && !rready_i.
- Reset mid-frame: frame abandoned, FIFO flushed, FSM IDLE; line low at reset release is treated as a new start edge.
- Counter widths: timer $clog2(WAIT_COUNT) bits, bit counter $clog2(DATA_BITS+1) bits, FIFO pointers $clog2(FIFO_DEPTH)+1 bits (wrap bit distinguishes full/empty).

Optional Feature:
UART_RX_PARITY_EN: defined -> PARITY state after last data bit; one parity bit sampled at midpoint; perr = (XOR of data bits ^ parity bit) != PARITY_ODD; perr stored with word, shown on rperr_o. Undefined -> no parity bit expected (DATA -> STOP directly), rperr_o tied 0, no parity storage.

Test Plan:
- CLK_FREQ_MHZ=10, BAUD_RATE=1000000 (WAIT_COUNT=10), rready_i=1, send 0xA5 8N1 -> rvalid_o pulses 1 cycle, rdata_o=0xA5, rferr_o=0, within 1 cycle after stop-bit midpoint.
- rxd_i low for 3 cycles then high -> no push, FSM back to IDLE; following 0x3C frame received correctly.
- Stop bit driven 0 on 0x55 -> word 0x55 pushed with rferr_o=1; next frame 0x0F rferr_o=0.
- rready_i=0, FIFO_DEPTH=4, send 0x01..0x05 back-to-back -> overrun_o=1 after 5th stop bit; then drain -> 0x01,0x02,0x03,0x04 in order, rvalid_o=0; ovr_clr_i pulse -> overrun_o=0.
- DATA_BITS=7, STOP_BITS=2, send 0x7F then second stop bit low -> rdata_o=0x7F, rferr_o=1.
- UART_RX_PARITY_EN, PARITY_ODD=0: 0x03 with parity 0 -> rperr_o=0; 0x03 with parity 1 -> rperr_o=1; assert rst_ni=0 mid-data-bit -> rvalid_o=0, FIFO empty after reset.
